turbo_out_packer: RTL and testbench

- Downstream neighbour of the turbo encoder top level; consumes its serial out0/out1/valid pair stream on the fast clock.
- Packs coded bit pairs LSB-first into bytes and tags the last byte of each encoder frame.
- Buffers bytes in a small FIFO and presents them on a valid/ready byte interface to the transmit/SRAM writer.
- Pads partial final bytes, and flags overflow instead of stalling, because the encoder cannot be back-pressured.

---
 rtl/turbo_pkg.sv | 19 +
 rtl/turbo_out_packer_if.sv | 24 ++
 rtl/byte_fifo.sv | 59 +++++
 rtl/turbo_out_packer.sv | 84 ++++++++
 tb/tb_turbo_out_packer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// Shared constants and payload types for the turbo encoder output path.
package turbo_pkg;

  localparam int unsigned PAIRS_PER_BYTE      = 4;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned DEFAULT_FRAME_PAIRS = 12;
  localparam int unsigned ENTRY_W             = BYTE_W + 1;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } byte_entry_t;

  // Bytes emitted per encoder frame, including a padded final byte.
  function automatic int unsigned bytes_per_frame(input int unsigned frame_pairs);
    return (frame_pairs + PAIRS_PER_BYTE - 1) / PAIRS_PER_BYTE;
  endfunction

endpackage

// File: rtl/turbo_out_packer_if.sv
// Pair-stream input and byte-stream output of the turbo output packer.
interface turbo_out_packer_if;
  import turbo_pkg::*;

  logic              in0;
  logic              in1;
  logic              in_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              overflow;
  logic [7:0]        frame_cnt;

  modport master (
    output in0, in1, in_valid, out_ready,
    input  out_data, out_last, out_valid, overflow, frame_cnt
  );

  modport slave (
    input  in0, in1, in_valid, out_ready,
    output out_data, out_last, out_valid, overflow, frame_cnt
  );
endinterface

// File: rtl/byte_fifo.sv
// Show-ahead FIFO; the head is a register so it holds its value once drained.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    w_rd_next;
  logic             w_rd;
  logic             w_wr;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_rd      = rd_en && !empty;
  assign w_wr      = wr_en && (!full || w_rd);
  assign w_rd_next = r_rd_ptr + AW'(1);
  assign rd_data   = r_head;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= w_rd_next;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Head tracks the oldest entry; a write into an emptying FIFO lands directly here.
      if (w_rd && (r_count > CW'(1)))
        r_head <= r_mem[w_rd_next];
      else if (w_wr && ((r_count == '0) || (w_rd && (r_count == CW'(1)))))
        r_head <= wr_data;
    end
  end
endmodule

// File: rtl/turbo_out_packer.sv
// Packs encoder bit pairs LSB-first into bytes, tags frame ends, and buffers them.
module turbo_out_packer
  import turbo_pkg::*;
#(
  parameter int unsigned FRAME_PAIRS = DEFAULT_FRAME_PAIRS,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  turbo_out_packer_if.slave  bus
);
  localparam int unsigned PC_W = 8;
  localparam int unsigned SL_W = 2;

  logic [PC_W-1:0]   r_pc;
  logic [SL_W-1:0]   r_sl;
  logic [BYTE_W-1:0] r_shift;
  logic              r_overflow;
  logic [7:0]        r_frame_cnt;

  logic              w_end;
  logic              w_full_byte;
  logic              w_complete;
  logic [BYTE_W-1:0] w_byte;
  byte_entry_t       w_entry;
  byte_entry_t       w_head;
  logic              w_full;
  logic              w_empty;

  assign w_end       = (r_pc == PC_W'(FRAME_PAIRS - 1));
  assign w_full_byte = (r_sl == SL_W'(PAIRS_PER_BYTE - 1));
  assign w_complete  = bus.in_valid && (w_end || w_full_byte);
  assign w_byte      = r_shift | (BYTE_W'({bus.in1, bus.in0}) << {r_sl, 1'b0});

  always_comb begin
    w_entry      = '0;
    w_entry.last = w_end;
    w_entry.data = w_byte;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_complete),
    .wr_data (w_entry),
    .rd_en   (bus.out_ready),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Counters advance even when a byte is dropped so framing stays aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_sl        <= '0;
      r_shift     <= '0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_complete && w_full && !bus.out_ready) r_overflow <= 1'b1;
      if (bus.in_valid) begin
        r_shift <= w_complete ? '0 : w_byte;
        if (w_end) begin
          r_pc        <= '0;
          r_sl        <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_pc <= r_pc + PC_W'(1);
          r_sl <= r_sl + SL_W'(1);
        end
      end
    end
  end

  assign bus.out_data  = w_head.data;
  assign bus.out_last  = w_head.last;
  assign bus.out_valid = !w_empty;
  assign bus.overflow  = r_overflow;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_turbo_out_packer.sv
// Directed-plus-random bench for turbo_out_packer against a frame-level byte model.
module tb_turbo_out_packer;
  import turbo_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  turbo_out_packer_if ifa ();
  turbo_out_packer_if ifb ();

  turbo_out_packer #(.FRAME_PAIRS(12), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  turbo_out_packer #(.FRAME_PAIRS(6), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int sel      = 0;

  // Reference model: pair index within the frame, byte accumulator, output queue.
  int          m_fp;
  int          m_n;
  int          m_acc;
  int          m_frames;
  bit          m_ovf;
  logic [8:0]  m_q[$];
  logic [7:0]  m_data;
  logic        m_last;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_acc = 0; m_frames = 0; m_ovf = 0;
    m_q.delete();
    m_data = '0; m_last = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit b0, input bit b1, input bit r);
    bit done, lst;
    logic [8:0] e;
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (v) begin
      m_acc = m_acc + (int'(b0) + 2 * int'(b1)) * (4 ** (m_n % 4));
      lst   = (m_n == m_fp - 1);
      done  = (m_n % 4 == 3) || lst;
      if (done) begin
        e = {lst, 8'(m_acc)};
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_ovf = 1'b1;
        m_acc = 0;
      end
      if (lst) begin
        m_n = 0;
        m_frames = (m_frames + 1) % 256;
      end else begin
        m_n++;
      end
    end
    if (m_q.size() > 0) {m_last, m_data} = m_q[0];
  endtask

  task automatic check_all();
    logic ov, ol, oo;
    logic [7:0] od, fc;
    if (sel == 0) begin
      ov = ifa.out_valid; ol = ifa.out_last; oo = ifa.overflow; od = ifa.out_data; fc = ifa.frame_cnt;
    end else begin
      ov = ifb.out_valid; ol = ifb.out_last; oo = ifb.overflow; od = ifb.out_data; fc = ifb.frame_cnt;
    end
    chk("out_valid", 16'(ov), 16'(m_q.size() > 0));
    chk("out_data",  16'(od), 16'(m_data));
    chk("out_last",  16'(ol), 16'(m_last));
    chk("overflow",  16'(oo), 16'(m_ovf));
    chk("frame_cnt", 16'(fc), 16'(m_frames));
  endtask

  task automatic idle_all();
    ifa.in_valid = 1'b0; ifa.in0 = 1'b0; ifa.in1 = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in0 = 1'b0; ifb.in1 = 1'b0; ifb.out_ready = 1'b0;
  endtask

  task automatic step(input bit v, input bit b0, input bit b1, input bit r);
    if (sel == 0) begin
      ifa.in_valid = v; ifa.in0 = b0; ifa.in1 = b1; ifa.out_ready = r;
    end else begin
      ifb.in_valid = v; ifb.in0 = b0; ifb.in1 = b1; ifb.out_ready = r;
    end
    @(posedge clk);
    model_edge(v, b0, b1, r);
    #1;
    check_all();
  endtask

  task automatic rand_pairs(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom % 2), 1'($urandom % 2), r);
  endtask

  task automatic idles(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid_a", 16'(ifa.out_valid), 16'h0);
    chk("rst_data_a",  16'(ifa.out_data),  16'h0);
    chk("rst_last_a",  16'(ifa.out_last),  16'h0);
    chk("rst_ovf_a",   16'(ifa.overflow),  16'h0);
    chk("rst_fcnt_a",  16'(ifa.frame_cnt), 16'h0);
    chk("rst_valid_b", 16'(ifb.out_valid), 16'h0);
    chk("rst_data_b",  16'(ifb.out_data),  16'h0);
    chk("rst_ovf_b",   16'(ifb.overflow),  16'h0);
    model_reset();
    idle_all();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    sel   = 0;
    m_fp  = 12;
    model_reset();
    #3;
    do_reset();

    // Basic packing: first byte 0x39, then the rest of a 12-pair frame.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("first_byte",  16'(ifa.out_data),  16'h39);
    chk("first_valid", 16'(ifa.out_valid), 16'h1);
    rand_pairs(8, 1'b1);
    idles(3, 1'b1);
    chk("basic_fcnt", 16'(ifa.frame_cnt), 16'h1);

    // Backpressure: four bytes held, then drained.
    rand_pairs(16, 1'b0);
    chk("bp_held", 16'(ifa.out_valid), 16'h1);
    idles(5, 1'b1);

    // Full FIFO with a read on the edge a fifth byte completes.
    rand_pairs(16, 1'b0);
    rand_pairs(3, 1'b0);
    step(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
    idles(1, 1'b0);
    idles(6, 1'b1);
    chk("simul_no_ovf", 16'(ifa.overflow), 16'h0);

    // Overflow: drop one byte, then confirm framing in following frames.
    rand_pairs(16, 1'b0);
    rand_pairs(4, 1'b0);
    chk("ovf_set", 16'(ifa.overflow), 16'h1);
    idles(2, 1'b0);
    idles(6, 1'b1);
    rand_pairs(16, 1'b1);
    idles(3, 1'b1);
    chk("ovf_sticky", 16'(ifa.overflow), 16'h1);

    // Reset mid-frame, then a clean frame.
    rand_pairs(5, 1'b1);
    do_reset();
    rand_pairs(12, 1'b1);
    idles(3, 1'b1);
    chk("post_rst_fcnt", 16'(ifa.frame_cnt), 16'h1);

    // Random in_valid gaps and random ready.
    for (int i = 0; i < 60; i++)
      step(1'($urandom % 3 != 0), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    idles(6, 1'b1);

    // Padding instance: 6 pairs per frame.
    sel  = 1;
    m_fp = 6;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("pad_byte0", 16'(ifb.out_data), 16'hFF);
    chk("pad_last0", 16'(ifb.out_last), 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("pad_byte1", 16'(ifb.out_data), 16'h0F);
    chk("pad_last1", 16'(ifb.out_last), 16'h1);
    idles(3, 1'b1);
    for (int i = 0; i < 40; i++)
      step(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    idles(6, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
